// File: rtl/hub75_rx_pkg.sv
// hub75_rx_pkg: shared idle pad levels and on-time FSM encoding for the HUB75 receiver
package hub75_rx_pkg;
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_ON   = 1'b1
  } ontime_state_t;
  localparam logic CLK_IDLE   = 1'b1;
  localparam logic LE_IDLE    = 1'b0;
  localparam logic BLANK_IDLE = 1'b1;
  localparam int CTL_CLK   = 0;
  localparam int CTL_LE    = 1;
  localparam int CTL_BLANK = 2;
  localparam logic [2:0] CTL_IDLE = {BLANK_IDLE, LE_IDLE, CLK_IDLE};
endpackage

// File: rtl/hub75_rx_sync.sv
// hub75_rx_sync: multi-flop synchronizer for a group of asynchronous pads with a settable idle value
module hub75_rx_sync #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] st;
  // shift the pad group through the synchronizer chain, resetting to its idle level
  always_ff @(posedge clk)
    if (rst) st <= {STAGES{RST_VAL}};
    else     st <= {st[STAGES-2:0], d};
  assign q = st[STAGES-1];
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver decoding pixel writes, line latches and blank on-times
module hub75_rx
  import hub75_rx_pkg::*;
#(
  parameter int N_BANKS = 2,
  parameter int N_ROWS = 32,
  parameter int N_COLS = 64,
  parameter int N_CHANS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ONTIME_W = 16,
  parameter int SDW = N_BANKS * N_CHANS,
  parameter int LOG_N_ROWS = $clog2(N_ROWS),
  parameter int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG_N_ROWS-1:0] hub75_addr,
  input  logic [SDW-1:0]        hub75_data,
  input  logic                  hub75_clk,
  input  logic                  hub75_le,
  input  logic                  hub75_blank,
  output logic                  wr_ena,
  output logic [LOG_N_COLS-1:0] wr_col,
  output logic [SDW-1:0]        wr_data,
  output logic                  line_stb,
  output logic [LOG_N_ROWS-1:0] line_row,
  output logic [LOG_N_COLS:0]   line_len,
  output logic                  line_ovf,
  output logic                  ontime_stb,
  output logic [ONTIME_W-1:0]   ontime
);
  localparam logic [LOG_N_COLS:0] COLS = (LOG_N_COLS+1)'(N_COLS);
  logic [LOG_N_ROWS-1:0] s_addr;
  logic [SDW-1:0] s_data;
  logic [2:0] s_ctl, p_ctl;
  logic shift_edge, latch_edge, blank_fall, blank_rise;
  logic [LOG_N_COLS:0] col_cnt, col_nxt;
  logic ovf, ovf_nxt, wr_go;
  ontime_state_t state, state_n;
  logic cnt_start, cnt_done;
  logic [ONTIME_W-1:0] cnt;

  hub75_rx_sync #(.W(LOG_N_ROWS), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_addr (
    .clk(clk), .rst(rst), .d(hub75_addr), .q(s_addr)
  );
  hub75_rx_sync #(.W(SDW), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_data (
    .clk(clk), .rst(rst), .d(hub75_data), .q(s_data)
  );
  hub75_rx_sync #(.W(3), .STAGES(SYNC_STAGES), .RST_VAL(CTL_IDLE)) u_sync_ctl (
    .clk(clk), .rst(rst), .d({hub75_blank, hub75_le, hub75_clk}), .q(s_ctl)
  );

  // previous-cycle copy of the control pads for edge detection
  always_ff @(posedge clk)
    if (rst) p_ctl <= CTL_IDLE;
    else     p_ctl <= s_ctl;

  assign shift_edge = s_ctl[CTL_CLK] & ~p_ctl[CTL_CLK];
  assign latch_edge = s_ctl[CTL_LE] & ~p_ctl[CTL_LE];
  assign blank_fall = ~s_ctl[CTL_BLANK] & p_ctl[CTL_BLANK];
  assign blank_rise = s_ctl[CTL_BLANK] & ~p_ctl[CTL_BLANK];

  // column bookkeeping including a shift that coincides with the latch edge
  always_comb begin
    wr_go   = shift_edge && (col_cnt != COLS);
    col_nxt = wr_go ? col_cnt + 1'b1 : col_cnt;
    ovf_nxt = ovf | (shift_edge && (col_cnt == COLS));
  end

  // registered pixel write strobe with held column and data
  always_ff @(posedge clk)
    if (rst) begin
      wr_ena  <= 1'b0;
      wr_col  <= '0;
      wr_data <= '0;
    end else begin
      wr_ena <= wr_go;
      if (wr_go) begin
        wr_col  <= col_cnt[LOG_N_COLS-1:0];
        wr_data <= s_data;
      end
    end

  // column counter, overflow flag and line latch reporting
  always_ff @(posedge clk)
    if (rst) begin
      col_cnt  <= '0;
      ovf      <= 1'b0;
      line_stb <= 1'b0;
      line_row <= '0;
      line_len <= '0;
      line_ovf <= 1'b0;
    end else begin
      line_stb <= latch_edge;
      col_cnt  <= latch_edge ? '0 : col_nxt;
      ovf      <= latch_edge ? 1'b0 : ovf_nxt;
      if (latch_edge) begin
        line_row <= s_addr;
        line_len <= col_nxt;
        line_ovf <= ovf_nxt;
      end
    end

  // on-time FSM state register
  always_ff @(posedge clk)
    if (rst) state <= ST_WAIT;
    else     state <= state_n;

  // on-time FSM transitions on blank edges
  always_comb begin
    state_n   = state;
    cnt_start = 1'b0;
    cnt_done  = 1'b0;
    cnt_start = (state == ST_WAIT) && blank_fall;
    cnt_done  = (state == ST_ON) && blank_rise;
    state_n   = cnt_start ? ST_ON : cnt_done ? ST_WAIT : state;
  end

  // saturating on-time counter and held result
  always_ff @(posedge clk)
    if (rst) begin
      cnt        <= '0;
      ontime_stb <= 1'b0;
      ontime     <= '0;
    end else begin
      ontime_stb <= cnt_done;
      if (cnt_done) ontime <= cnt;
      if (cnt_start) cnt <= ONTIME_W'(1);
      else if (state == ST_ON && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed self-checking bench for the HUB75 receiver
module tb_hub75_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] hub75_addr = '0;
  logic [5:0] hub75_data = '0;
  logic hub75_clk = 1'b1;
  logic hub75_le = 1'b0;
  logic hub75_blank = 1'b1;
  logic wr_ena, line_stb, line_ovf, ontime_stb;
  logic [5:0] wr_col, wr_data;
  logic [4:0] line_row;
  logic [6:0] line_len;
  logic [15:0] ontime;
  logic wr_ena8, line_stb8, line_ovf8, ontime_stb8;
  logic [5:0] wr_col8, wr_data8;
  logic [4:0] line_row8;
  logic [6:0] line_len8;
  logic [7:0] ontime8;

  hub75_rx dut (
    .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
    .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
    .wr_ena(wr_ena), .wr_col(wr_col), .wr_data(wr_data),
    .line_stb(line_stb), .line_row(line_row), .line_len(line_len), .line_ovf(line_ovf),
    .ontime_stb(ontime_stb), .ontime(ontime)
  );

  hub75_rx #(.ONTIME_W(8)) dut8 (
    .clk(clk), .rst(rst), .hub75_addr(hub75_addr), .hub75_data(hub75_data),
    .hub75_clk(hub75_clk), .hub75_le(hub75_le), .hub75_blank(hub75_blank),
    .wr_ena(wr_ena8), .wr_col(wr_col8), .wr_data(wr_data8),
    .line_stb(line_stb8), .line_row(line_row8), .line_len(line_len8), .line_ovf(line_ovf8),
    .ontime_stb(ontime_stb8), .ontime(ontime8)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  int wn = 0, ln = 0, on = 0, on8 = 0;
  int wcol [512];
  int wdat [512];
  int l_row = 0, l_len = 0, l_ovf = 0, o_val = 0, o8_val = 0;

  // record every strobe from the DUTs away from the active edge
  always @(negedge clk)
    if (!rst) begin
      if (wr_ena && wn < 512) begin
        wcol[wn] = int'(wr_col);
        wdat[wn] = int'(wr_data);
        wn++;
      end
      if (line_stb) begin
        l_row = int'(line_row);
        l_len = int'(line_len);
        l_ovf = int'(line_ovf);
        ln++;
      end
      if (ontime_stb) begin
        o_val = int'(ontime);
        on++;
      end
      if (ontime_stb8) begin
        o8_val = int'(ontime8);
        on8++;
      end
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input int d);
    hub75_data = 6'(d);
    hub75_clk = 1'b0;
    tick(4);
    hub75_clk = 1'b1;
    tick(4);
  endtask

  task automatic latch(input int a);
    hub75_addr = 5'(a);
    tick(2);
    hub75_le = 1'b1;
    tick(4);
    hub75_le = 1'b0;
    tick(8);
  endtask

  int base, lb, ob;

  initial begin
    tick(5);
    rst = 1'b0;
    tick(100);
    check("idle_writes", wn, 0);
    check("idle_lines", ln, 0);
    check("idle_ontime", on, 0);
    check("idle_wr_ena", int'(wr_ena), 0);
    check("idle_line_len", int'(line_len), 0);

    base = wn;
    for (int c = 0; c < 64; c++) shift_bit(c);
    latch(5);
    check("full_writes", wn - base, 64);
    for (int i = 0; i < 64; i++) begin
      check("full_col", wcol[base+i], i);
      check("full_data", wdat[base+i], i);
    end
    check("full_lines", ln, 1);
    check("full_row", l_row, 5);
    check("full_len", l_len, 64);
    check("full_ovf", l_ovf, 0);

    base = wn;
    lb = ln;
    for (int c = 0; c < 70; c++) shift_bit(c % 64);
    latch(1);
    check("ovf_writes", wn - base, 64);
    check("ovf_last_col", wcol[wn-1], 63);
    check("ovf_lines", ln - lb, 1);
    check("ovf_len", l_len, 64);
    check("ovf_flag", l_ovf, 1);
    base = wn;
    for (int c = 0; c < 3; c++) shift_bit(c + 40);
    latch(2);
    check("short_writes", wn - base, 3);
    check("short_data", wdat[wn-1], 42);
    check("short_row", l_row, 2);
    check("short_len", l_len, 3);
    check("short_ovf", l_ovf, 0);

    ob = on;
    hub75_blank = 1'b0;
    tick(200);
    hub75_blank = 1'b1;
    tick(10);
    check("ontime_strobes", on - ob, 1);
    check("ontime_200", o_val, 200);
    check("ontime8_200", o8_val, 200);
    hub75_blank = 1'b0;
    tick(300);
    hub75_blank = 1'b1;
    tick(10);
    check("ontime_300", o_val, 300);
    check("ontime8_sat", o8_val, 255);
    tick(20);
    check("ontime8_held", int'(ontime8), 255);
    check("ontime_strobes2", on - ob, 2);

    base = wn;
    lb = ln;
    for (int c = 0; c < 10; c++) shift_bit(c + 20);
    hub75_data = 6'd33;
    hub75_clk = 1'b0;
    tick(4);
    hub75_clk = 1'b1;
    hub75_le = 1'b1;
    hub75_addr = 5'd7;
    tick(4);
    hub75_le = 1'b0;
    tick(10);
    check("same_writes", wn - base, 11);
    check("same_col", wcol[base+10], 10);
    check("same_data", wdat[base+10], 33);
    check("same_lines", ln - lb, 1);
    check("same_row", l_row, 7);
    check("same_len", l_len, 11);

    base = wn;
    lb = ln;
    for (int c = 0; c < 20; c++) shift_bit(c);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("rst_lines_none", ln - lb, 0);
    latch(3);
    check("rst_writes", wn - base, 20);
    check("rst_last_col", wcol[wn-1], 19);
    check("rst_lines", ln - lb, 1);
    check("rst_len", l_len, 0);
    check("rst_row", l_row, 3);
    check("rst_ovf", l_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
